// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and line levels used by both TX and RX.
// Combinational content only; no timing or flow control of its own.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam int   DATA_BITS   = 8;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;

    function automatic logic calc_parity(input logic [DATA_BITS-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1, bit_tick on terminal count, pre_tick one clk before.
// No backpressure; clear holds the count at 0 so the first period starts cleanly.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_tick,
    output logic pre_tick
);

    localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clear || bit_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign bit_tick = (cnt == LAST);
    assign pre_tick = (cnt == PRE);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data LSB first, optional parity, 1 stop; tx goes low the clk after acceptance.
// One byte in flight; tx_ready only in IDLE, so a source must hold tx_valid until accepted.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter bit PARITY_EN    = 1'b1,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    uart_state_t          state;
    logic [DATA_BITS-1:0] shift;
    logic [2:0]           bit_idx;
    logic                 parity;
    logic                 bit_tick;
    logic                 pre_tick;
    logic                 baud_clear;

    assign baud_clear = (state == IDLE);
    assign tx_ready   = (state == IDLE);
    assign tx_busy    = (state != IDLE);

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (baud_clear),
        .bit_tick (bit_tick),
        .pre_tick (pre_tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            tx      <= IDLE_LEVEL;
            tx_done <= 1'b0;
            bit_idx <= '0;
            shift   <= '0;
            parity  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    tx <= IDLE_LEVEL;
                    if (tx_valid) begin
                        shift   <= tx_data;
                        parity  <= calc_parity(tx_data, PARITY_ODD);
                        bit_idx <= '0;
                        tx      <= START_LEVEL;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_tick) begin
                        tx    <= shift[0];
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        shift <= shift >> 1;
                        if (bit_idx == 3'(DATA_BITS - 1)) begin
                            bit_idx <= '0;
                            if (PARITY_EN) begin
                                tx    <= parity;
                                state <= PARITY;
                            end else begin
                                tx    <= STOP_LEVEL;
                                state <= STOP;
                            end
                        end else begin
                            // shift[1] is the bit that lands in shift[0] on this same edge
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shift[1];
                        end
                    end
                end
                PARITY: begin
                    if (bit_tick) begin
                        tx    <= STOP_LEVEL;
                        state <= STOP;
                    end
                end
                STOP: begin
                    // pre_tick lands tx_done exactly on the last clk of the stop bit
                    if (pre_tick) tx_done <= 1'b1;
                    if (bit_tick) begin
                        tx    <= IDLE_LEVEL;
                        state <= IDLE;
                    end
                end
                default: begin
                    tx    <= IDLE_LEVEL;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Transmit half of the team UART; the serialising counterpart to the receiver chain (start detect, data capture, parity check, stop gating).
- Accepts one byte per valid/ready handshake and drives an 8-bit frame on a single serial line: start bit, 8 data bits LSB first, optional parity bit, 1 stop bit.
- Bit timing comes from an internal clock-divide counter. The block sits between the host-side byte source and the TX pin.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200); legal range 2..65535.
- PARITY_EN, 1, 1 = parity bit inserted after data; 0 = no parity bit.
- PARITY_ODD, 0, 0 = even parity (XOR of data); 1 = odd parity (inverted XOR); ignored when PARITY_EN=0.

Ports:
- clk  input  1  single system clock; all logic on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- tx_data  input  8  byte to send; sampled only on acceptance.
- tx_valid  input  1  source has a byte on tx_data.
- tx_ready  output  1  block can accept; high only in IDLE.
- tx  output  1  serial line; idles high.
- tx_busy  output  1  high from the cycle after acceptance until the end of the stop bit.
- tx_done  output  1  one-cycle pulse on the last clk of the stop bit.

Behaviour:
- Reset (rst_n low at a rising edge): state=IDLE, tx=1, tx_ready=1, tx_busy=0, tx_done=0, bit counter=0, clk-divide counter=0, shift register=0.
- Acceptance: tx_valid && tx_ready at a rising edge. tx_data is latched into the shift register, parity is computed from tx_data and registered, and the state moves to START. tx_valid while tx_ready=0 is ignored; there is no queueing.
- State machine: IDLE -> START -> DATA -> (PARITY if PARITY_EN) -> STOP -> IDLE.
- Every bit state lasts exactly CLKS_PER_BIT cycles. The clk-divide counter counts 0..CLKS_PER_BIT-1, advances state on the terminal count, and reloads 0 on each state change.
- START: tx=0.
- DATA: tx=shift[0], and the register shifts right at each bit boundary. A 3-bit counter selects bits 0..7; DATA exits when the counter is 7 and the divider is at terminal count.
- PARITY: tx=registered parity bit.
- STOP: tx=1. tx_done=1 in its last cycle; then IDLE.
- Latency: acceptance at edge N drives tx=0 from cycle N+1. Frame length is 10 bit periods without parity and 11 with parity.
- Back-to-back: tx_ready returns high in the IDLE cycle after STOP, so the minimum gap between stop-bit end and the next start bit is 1 clk of idle-high.
- tx is registered (no combinational path from inputs). tx_ready and tx_busy are decodes of the state register.
- Reset mid-frame: abort on the next edge, tx=1 immediately, no tx_done pulse, and the byte is discarded.
- tx_data changes after acceptance have no effect on the frame in flight.
- Illegal or unused state encodings recover to IDLE with tx=1.

Decomposition:
- Shared package/header uart_pkg:
  - state encodings IDLE/START/DATA/PARITY/STOP, shared with the receiver FSM;
  - DATA_BITS=8, START_LEVEL=0, STOP_LEVEL=1, IDLE_LEVEL=1.
- One sub-module is natural: uart_baud_cnt.
  - Parameterised by CLKS_PER_BIT.
  - Inputs: clk, rst_n, clear.
  - Output: bit_tick on the terminal count.
  - It is reusable by the receiver for mid-bit sampling.

Test Plan:
- Reset idle: hold rst_n=0 for 5 cycles, then release with tx_valid=0 for 100 cycles -> tx=1, tx_ready=1, tx_busy=0, tx_done=0 throughout.
- Single frame, CLKS_PER_BIT=4, PARITY_EN=1, PARITY_ODD=0, tx_data=8'hA5 -> tx sequence per 4-clk bit: 0,1,0,1,0,0,1,0,1,0(parity, even of four 1s),1. The start bit begins the cycle after acceptance, and tx_done pulses once at cycle 44 after acceptance.
- Odd parity / no parity: 8'h01 with PARITY_ODD=1 -> parity bit 0. The same byte with PARITY_EN=0 -> 10-bit frame, and tx_done comes 40 cycles after acceptance.
- Busy rejection: accept 8'h3C, then pulse tx_valid with 8'hFF mid-DATA -> tx_ready=0, the frame still carries 3C, and no second frame is sent.
- Back-to-back: hold tx_valid high with 8'h55 then 8'hAA -> two frames with exactly 1 idle-high clk between the stop end and the second start bit.
- Reset mid-frame: assert rst_n=0 during data bit 3 of 8'hF0 -> tx=1 on the next edge, no tx_done. A new byte 8'h0F after release is sent intact.
